// File: rtl/spi_master_arbiter.sv
// rtl/spi_master_arbiter.sv - two-requester round-robin arbiter in front of an SPI master driver
module spi_master_arbiter #(
  parameter int DATA_W    = 8,
  parameter int START_TMO = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req0_i,
  input  logic              req1_i,
  input  logic [DATA_W-1:0] data0_bi,
  input  logic [DATA_W-1:0] data1_bi,
  output logic              ack0_o,
  output logic              ack1_o,
  output logic [DATA_W-1:0] data0_bo,
  output logic [DATA_W-1:0] data1_bo,
  output logic              err_o,
  output logic [1:0]        grant_bo,
  output logic              drv_start_o,
  output logic [DATA_W-1:0] drv_data_bo,
  input  logic              drv_busy_i,
  input  logic [DATA_W-1:0] drv_data_bi
);

  typedef enum logic [1:0] {IDLE, START, XFER, DONE} state_t;

  localparam logic [4:0] TMO_LAST = 5'(START_TMO - 1);

  state_t            state_q, state_d;
  logic              owner_q, owner_d;
  logic              last_q, last_d;
  logic              win;
  logic [4:0]        cnt_q, cnt_d;
  logic [1:0]        grant_q, grant_d;
  logic [1:0]        ack_q, ack_d;
  logic              start_q, start_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] tx_q, tx_d;
  logic [DATA_W-1:0] rx0_q, rx0_d;
  logic [DATA_W-1:0] rx1_q, rx1_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      cnt_q   <= '0;
      grant_q <= '0;
      ack_q   <= '0;
      start_q <= 1'b0;
      err_q   <= 1'b0;
      tx_q    <= '0;
      rx0_q   <= '0;
      rx1_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      grant_q <= grant_d;
      ack_q   <= ack_d;
      start_q <= start_d;
      err_q   <= err_d;
      tx_q    <= tx_d;
      rx0_q   <= rx0_d;
      rx1_q   <= rx1_d;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    grant_d = grant_q;
    start_d = start_q;
    tx_d    = tx_q;
    rx0_d   = rx0_q;
    rx1_d   = rx1_q;
    ack_d   = 2'b00;
    err_d   = 1'b0;
    win     = 1'b0;
    case (state_q)
      IDLE: begin
        // On a tie the requester not served last wins.
        win = (req0_i && req1_i) ? ~last_q : req1_i;
        if ((req0_i || req1_i) && !drv_busy_i) begin
          owner_d = win;
          grant_d = win ? 2'b10 : 2'b01;
          tx_d    = win ? data1_bi : data0_bi;
          cnt_d   = '0;
          start_d = 1'b1;
          state_d = START;
        end
      end
      START: begin
        if (drv_busy_i) begin
          start_d = 1'b0;
          state_d = XFER;
        end else if (cnt_q == TMO_LAST) begin
          start_d = 1'b0;
          ack_d   = owner_q ? 2'b10 : 2'b01;
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
      XFER: begin
        if (!drv_busy_i) begin
          ack_d = owner_q ? 2'b10 : 2'b01;
          if (owner_q) rx1_d = drv_data_bi;
          else         rx0_d = drv_data_bi;
          state_d = DONE;
        end
      end
      DONE: begin
        grant_d = 2'b00;
        last_d  = owner_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign ack0_o      = ack_q[0];
  assign ack1_o      = ack_q[1];
  assign err_o       = err_q;
  assign grant_bo    = grant_q;
  assign drv_start_o = start_q;
  assign drv_data_bo = tx_q;
  assign data0_bo    = rx0_q;
  assign data1_bo    = rx1_q;

endmodule

// File: tb/tb_spi_master_arbiter.sv
// tb/tb_spi_master_arbiter.sv - randomized bench with a transaction-level round-robin model
module tb_spi_master_arbiter;
  localparam int DW  = 8;
  localparam int TMO = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          req0, req1;
  logic [DW-1:0] d0, d1;
  logic          ack0, ack1, err, start, busy;
  logic [DW-1:0] q0, q1, drv_tx, drv_rx;
  logic [1:0]    grant;

  int total = 0;
  int bad = 0;
  int ack0_cnt = 0, ack1_cnt = 0, err_cnt = 0, start_cnt = 0;
  logic start_prev = 1'b0;

  int            m_last;
  logic [DW-1:0] m_rx [2];
  int            order_q [$];

  always #5 clk = ~clk;

  spi_master_arbiter #(.DATA_W(DW), .START_TMO(TMO)) dut (
    .clk_i(clk), .rst_i(rst),
    .req0_i(req0), .req1_i(req1),
    .data0_bi(d0), .data1_bi(d1),
    .ack0_o(ack0), .ack1_o(ack1),
    .data0_bo(q0), .data1_bo(q1),
    .err_o(err), .grant_bo(grant),
    .drv_start_o(start), .drv_data_bo(drv_tx),
    .drv_busy_i(busy), .drv_data_bi(drv_rx)
  );

  always @(negedge clk) begin
    ack0_cnt += int'(ack0);
    ack1_cnt += int'(ack1);
    err_cnt  += int'(err);
    if (start && !start_prev) start_cnt++;
    start_prev = start;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  function automatic int model_pick(input logic r0, input logic r1);
    if (r0 && r1) return (m_last == 0) ? 1 : 0;
    return r1 ? 1 : 0;
  endfunction

  task automatic model_reset();
    m_last  = 1;
    m_rx[0] = '0;
    m_rx[1] = '0;
  endtask

  task automatic wait_start(output bit ok);
    int n = 0;
    while (!start && n < 20) begin
      tick();
      n++;
    end
    ok = start;
    total++;
    if (!start) begin
      bad++;
      $display("FAIL wait_start: drv_start_o=%0b required 1 within 20 cycles", start);
    end
  endtask

  // Plays the slave side: busy after dly cycles, held blen cycles, then returns sval.
  task automatic serve(input int dly, input int blen, input logic [DW-1:0] sval,
                       output int who, output logic [DW-1:0] tx, output bit ok);
    who = -1;
    tx  = '0;
    wait_start(ok);
    if (!ok) return;
    who = (grant == 2'b10) ? 1 : ((grant == 2'b01) ? 0 : -1);
    tx  = drv_tx;
    repeat (dly) tick();
    busy = 1'b1;
    tick();
    total++;
    if (start !== 1'b0) begin
      bad++;
      $display("FAIL start_drop: drv_start_o=%0b required 0", start);
    end
    repeat (blen) tick();
    busy   = 1'b0;
    drv_rx = sval;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0; d0 = '0; d1 = '0; busy = 1'b0; drv_rx = '0;
    tick();
    tick();
    total++;
    if ({ack0, ack1, err, start} !== 4'b0000) begin
      bad++;
      $display("FAIL reset_ctl: ack0,ack1,err,start=%b required 0000", {ack0, ack1, err, start});
    end
    total++;
    if (grant !== 2'b00) begin
      bad++;
      $display("FAIL reset_grant: grant=%b required 00", grant);
    end
    total++;
    if (drv_tx !== '0 || q0 !== '0 || q1 !== '0) begin
      bad++;
      $display("FAIL reset_data: drv=%h q0=%h q1=%h required 00", drv_tx, q0, q1);
    end
    rst = 1'b0;
    tick();
    model_reset();
  endtask

  task automatic test_single();
    int who;
    logic [DW-1:0] tx;
    bit ok;
    int s0 = start_cnt;
    int a0 = ack0_cnt;
    d0 = 8'hAC;
    req0 = 1'b1;
    serve(1, 3, 8'hA5, who, tx, ok);
    total++;
    if (who != 0 || tx !== 8'hAC) begin
      bad++;
      $display("FAIL single_grant: owner=%0d tx=%h required 0 ac", who, tx);
    end
    total++;
    if ({ack1, ack0, err} !== 3'b010 || q0 !== 8'hA5) begin
      bad++;
      $display("FAIL single_ack: ack1,ack0,err=%b q0=%h required 010 a5", {ack1, ack0, err}, q0);
    end
    req0 = 1'b0;
    repeat (4) tick();
    total++;
    if (start_cnt - s0 != 1 || ack0_cnt - a0 != 1 || grant !== 2'b00) begin
      bad++;
      $display("FAIL single_count: starts=%0d acks=%0d grant=%b required 1 1 00",
               start_cnt - s0, ack0_cnt - a0, grant);
    end
    m_last  = 0;
    m_rx[0] = 8'hA5;
  endtask

  task automatic run_transfers(input int n, input bit drop_on_ack, input bit rand_req);
    for (int i = 0; i < n; i++) begin
      int exp, who, pat;
      logic [DW-1:0] tx, sv;
      bit ok;
      if (rand_req) begin
        pat  = $urandom_range(1, 3);
        req0 = pat[0];
        req1 = pat[1];
        d0   = DW'($urandom);
        d1   = DW'($urandom);
      end
      exp = model_pick(req0, req1);
      sv  = DW'($urandom);
      serve($urandom_range(0, 3), $urandom_range(0, 4), sv, who, tx, ok);
      if (!ok) return;
      total++;
      if (who != exp) begin
        bad++;
        $display("FAIL rr_owner: xfer %0d owner=%0d required %0d", i, who, exp);
      end
      total++;
      if (tx !== (exp != 0 ? d1 : d0) || drv_tx !== tx) begin
        bad++;
        $display("FAIL drv_data: xfer %0d at_start=%h at_ack=%h required %h",
                 i, tx, drv_tx, exp != 0 ? d1 : d0);
      end
      total++;
      if ({ack1, ack0} !== (exp != 0 ? 2'b10 : 2'b01) || err !== 1'b0) begin
        bad++;
        $display("FAIL xfer_ack: xfer %0d ack1,ack0=%b err=%b required owner %0d err 0",
                 i, {ack1, ack0}, err, exp);
      end
      total++;
      if ((exp != 0 ? q1 : q0) !== sv || (exp != 0 ? q0 : q1) !== m_rx[1-exp]) begin
        bad++;
        $display("FAIL rx_data: xfer %0d q0=%h q1=%h required owner %0d gets %h other %h",
                 i, q0, q1, exp, sv, m_rx[1-exp]);
      end
      order_q.push_back(who);
      m_last    = exp;
      m_rx[exp] = sv;
      if (drop_on_ack) begin
        if (exp != 0) req1 = 1'b0;
        else          req0 = 1'b0;
      end
      tick();
      total++;
      if (grant !== 2'b00 || ack0 !== 1'b0 || ack1 !== 1'b0) begin
        bad++;
        $display("FAIL done_exit: grant=%b ack0=%b ack1=%b required 00 0 0", grant, ack0, ack1);
      end
    end
  endtask

  task automatic test_simultaneous();
    int a0, a1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_reset();
    a0 = ack0_cnt;
    a1 = ack1_cnt;
    order_q.delete();
    d0 = 8'h11; d1 = 8'h22;
    req0 = 1'b1; req1 = 1'b1;
    run_transfers(2, 1'b1, 1'b0);
    repeat (3) tick();
    total++;
    if (order_q.size() != 2 || order_q[0] != 0 || order_q[1] != 1
        || ack0_cnt - a0 != 1 || ack1_cnt - a1 != 1) begin
      bad++;
      $display("FAIL simul_order: served=%0d first=%0d acks=%0d/%0d required 2 0 1/1",
               order_q.size(), order_q.size() > 0 ? order_q[0] : -1,
               ack0_cnt - a0, ack1_cnt - a1);
    end
  endtask

  task automatic test_fairness();
    bit good = 1'b1;
    order_q.delete();
    d0 = DW'($urandom); d1 = DW'($urandom);
    req0 = 1'b1; req1 = 1'b1;
    run_transfers(4, 1'b0, 1'b0);
    req0 = 1'b0; req1 = 1'b0;
    tick();
    if (order_q.size() != 4) good = 1'b0;
    else for (int i = 0; i < 4; i++) if (order_q[i] != i % 2) good = 1'b0;
    total++;
    if (!good) begin
      bad++;
      $display("FAIL fairness: served=%0d transfers, order not 0,1,0,1", order_q.size());
    end
  endtask

  task automatic test_random();
    run_transfers(20, 1'b1, 1'b1);
    req0 = 1'b0; req1 = 1'b0;
    repeat (2) tick();
  endtask

  task automatic test_timeout();
    logic [DW-1:0] keep = q1;
    int n = 0;
    int e0 = err_cnt;
    bit ok;
    busy = 1'b0;
    d1 = DW'($urandom);
    req1 = 1'b1;
    wait_start(ok);
    total++;
    if (grant !== 2'b10) begin
      bad++;
      $display("FAIL tmo_grant: grant=%b required 10", grant);
    end
    while (!ack1 && n < 40) begin
      tick();
      n++;
    end
    total++;
    if (n != TMO || err !== 1'b1 || ack0 !== 1'b0 || start !== 1'b0) begin
      bad++;
      $display("FAIL tmo_ack: cycles=%0d err=%b ack0=%b start=%b required %0d 1 0 0",
               n, err, ack0, start, TMO);
    end
    total++;
    if (q1 !== keep) begin
      bad++;
      $display("FAIL tmo_data: q1=%h required %h", q1, keep);
    end
    req1 = 1'b0;
    tick();
    total++;
    if (err !== 1'b0 || ack1 !== 1'b0 || grant !== 2'b00 || err_cnt - e0 != 1) begin
      bad++;
      $display("FAIL tmo_exit: err=%b ack1=%b grant=%b errs=%0d required 0 0 00 1",
               err, ack1, grant, err_cnt - e0);
    end
    m_last = 1;
  endtask

  task automatic test_reset_mid();
    int a0 = ack0_cnt;
    int who;
    logic [DW-1:0] tx, sv;
    bit ok;
    d0 = DW'($urandom);
    req0 = 1'b1;
    wait_start(ok);
    busy = 1'b1;
    repeat (2) tick();
    rst = 1'b1;
    #1;
    total++;
    if ({ack0, ack1, err, start, grant} !== 6'b0 || drv_tx !== '0 || q0 !== '0 || q1 !== '0) begin
      bad++;
      $display("FAIL rst_mid: ctl=%b drv=%h q0=%h q1=%h required all 0",
               {ack0, ack1, err, start, grant}, drv_tx, q0, q1);
    end
    tick();
    rst = 1'b0; busy = 1'b0; req0 = 1'b0;
    repeat (2) tick();
    model_reset();
    total++;
    if (ack0_cnt != a0) begin
      bad++;
      $display("FAIL rst_noack: acks=%0d required 0", ack0_cnt - a0);
    end
    d0 = 8'h5A;
    req0 = 1'b1;
    sv = DW'($urandom);
    serve(2, 2, sv, who, tx, ok);
    total++;
    if (who != 0 || tx !== 8'h5A || ack0 !== 1'b1 || err !== 1'b0 || q0 !== sv) begin
      bad++;
      $display("FAIL rst_after: owner=%0d tx=%h ack0=%b err=%b q0=%h required 0 5a 1 0 %h",
               who, tx, ack0, err, q0, sv);
    end
    req0 = 1'b0;
    tick();
    m_last = 0;
  endtask

  task automatic test_withdraw();
    int a1 = ack1_cnt;
    int s0 = start_cnt;
    logic [DW-1:0] sv = DW'($urandom);
    bit ok;
    d1 = DW'($urandom);
    req1 = 1'b1;
    wait_start(ok);
    req1 = 1'b0;
    total++;
    if (grant !== 2'b10) begin
      bad++;
      $display("FAIL wd_grant: grant=%b required 10", grant);
    end
    tick();
    busy = 1'b1;
    repeat (3) tick();
    busy = 1'b0;
    drv_rx = sv;
    tick();
    total++;
    if (ack1 !== 1'b1 || q1 !== sv) begin
      bad++;
      $display("FAIL wd_ack: ack1=%b q1=%h required 1 %h", ack1, q1, sv);
    end
    repeat (6) tick();
    total++;
    if (ack1_cnt - a1 != 1 || start_cnt - s0 != 1 || grant !== 2'b00) begin
      bad++;
      $display("FAIL wd_idle: acks=%0d starts=%0d grant=%b required 1 1 00",
               ack1_cnt - a1, start_cnt - s0, grant);
    end
  endtask

  initial begin
    rst = 1'b1;
    test_reset();
    test_single();
    test_simultaneous();
    test_fairness();
    test_random();
    test_timeout();
    test_reset_mid();
    test_withdraw();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
